// File: rtl/top_ground_bank_seq.sv
// ---------------------------------------------------------------------------
// top_ground_bank_seq
//   Sequences the connection of a bank of ground-pad channels. On a connect
//   request the channels are switched on one at a time, lowest index first,
//   one step every STEP_CYC clocks. On release they are switched off in
//   reverse order. Each channel has a synchronised, debounced fault input.
//   A confirmed fault sets a sticky status flag and forces that channel off.
//
// Ports
//   CLK         clock; all state updates on its rising edge
//   RST_N       asynchronous active-low reset
//   EN_REQ      level request: 1 = connect the bank, 0 = disconnect it
//   CH_MASK     per-channel enable, captured when a ramp-up starts
//   FAULT_IN    asynchronous per-channel short/overcurrent indication
//   FAULT_CLR   clears the sticky fault flags (honoured in IDLE only)
//   G_CONN      registered per-channel ground-connect enable
//   EN_ACK      high while the bank is fully on
//   BUSY        high while ramping up or down
//   FAULT_STAT  sticky per-channel fault flags
//   STATE       0 = IDLE, 1 = RAMP_UP, 2 = ON, 3 = RAMP_DOWN
// ---------------------------------------------------------------------------
module top_ground_bank_seq #(
    parameter int NCH      = 4,
    parameter int STEP_CYC = 8,
    parameter int DBNC     = 4
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           EN_REQ,
    input  logic [NCH-1:0] CH_MASK,
    input  logic [NCH-1:0] FAULT_IN,
    input  logic           FAULT_CLR,
    output logic [NCH-1:0] G_CONN,
    output logic           EN_ACK,
    output logic           BUSY,
    output logic [NCH-1:0] FAULT_STAT,
    output logic [1:0]     STATE
);

    localparam int CW = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int DW = $clog2(DBNC + 1);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_RAMP_UP   = 2'd1;
    localparam logic [1:0] S_ON        = 2'd2;
    localparam logic [1:0] S_RAMP_DOWN = 2'd3;

    localparam logic [CW-1:0] CNT_LAST = CW'(STEP_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NCH - 1);
    localparam logic [DW-1:0] DBNC_MAX = DW'(DBNC);

    logic [1:0]     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [NCH-1:0] mask_q, mask_d;
    logic [NCH-1:0] gconn_q, gconn_d;
    logic [NCH-1:0] fstat_q, fstat_d;
    logic [NCH-1:0] sync1_q, sync2_q;
    logic [DW-1:0]  dbnc_q [NCH];
    logic [DW-1:0]  dbnc_d [NCH];
    logic           clr_ok;

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            mask_q  <= '0;
            gconn_q <= '0;
            fstat_q <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                dbnc_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            mask_q  <= mask_d;
            gconn_q <= gconn_d;
            fstat_q <= fstat_d;
            sync1_q <= FAULT_IN;
            sync2_q <= sync1_q;
            for (int i = 0; i < NCH; i++) begin
                dbnc_q[i] <= dbnc_d[i];
            end
        end
    end

    // Fault debounce. A clear keeps the flag of any channel whose synchronised
    // input is still high, so a persisting fault never appears to go away.
    always_comb begin
        clr_ok  = FAULT_CLR && (state_q == S_IDLE);
        fstat_d = clr_ok ? (fstat_q & sync2_q) : fstat_q;
        for (int i = 0; i < NCH; i++) begin
            dbnc_d[i] = dbnc_q[i];
            if (!sync2_q[i] || clr_ok) begin
                dbnc_d[i] = '0;
            end else if (dbnc_q[i] != DBNC_MAX) begin
                dbnc_d[i] = dbnc_q[i] + 1'b1;
            end
            if (dbnc_d[i] == DBNC_MAX) begin
                fstat_d[i] = 1'b1;
            end
        end
    end

    // Next-state logic for the sequencer
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        mask_d  = mask_q;
        gconn_d = gconn_q;
        case (state_q)
            S_IDLE: begin
                gconn_d = '0;
                if (EN_REQ) begin
                    state_d = S_RAMP_UP;
                    mask_d  = CH_MASK;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_RAMP_UP: begin
                if (!EN_REQ) begin
                    // Abort: unwind from the last channel actually stepped.
                    cnt_d = '0;
                    if (idx_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_RAMP_DOWN;
                        idx_d   = idx_q - 1'b1;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    gconn_d[idx_q] = mask_q[idx_q] & ~fstat_q[idx_q];
                    cnt_d          = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = S_ON;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ON: begin
                if (!EN_REQ) begin
                    state_d = S_RAMP_DOWN;
                    idx_d   = IDX_LAST;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (cnt_q == CNT_LAST) begin
                    gconn_d[idx_q] = 1'b0;
                    cnt_d          = '0;
                    if (idx_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q - 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
        // A fault confirmed on this edge beats a connect step on the same channel.
        gconn_d = gconn_d & ~fstat_d;
    end

    // Outputs decode straight from registers so reset reaches them at once.
    always_comb begin
        G_CONN     = gconn_q;
        FAULT_STAT = fstat_q;
        STATE      = state_q;
        EN_ACK     = (state_q == S_ON);
        BUSY       = (state_q == S_RAMP_UP) || (state_q == S_RAMP_DOWN);
    end

endmodule
